// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 8-bit value + operator code to 4-digit multiplexed 7-segment display
//
// Converts an 8-bit unsigned value to BCD with a sequential shift-add-3
// engine (IDLE -> SHIFT x8 -> COMMIT) and scans the three decimal digits plus
// an operator glyph onto a 4-digit display with a rotating one-hot strobe.
//
// Ports:
//   clk    - single clock
//   reset  - asynchronous, active-high reset
//   value  - unsigned binary value to display (0..255)
//   op     - operator key code; 0xA..0xF shown on digit 3, otherwise blank
//   load   - single-cycle strobe, captures value/op when idle (ignored while busy)
//   busy   - high while a conversion is in progress (SHIFT and COMMIT)
//   an     - one-hot active-high digit select: bit0 ones, bit1 tens, bit2 hundreds, bit3 operator
//   seg    - active-high segments, seg[0]=a .. seg[6]=g
//   dp     - decimal point, always 0
module seg7_scan_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic [3:0] op,
  input  logic       load,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // A divide of 1 still needs a 1-bit counter that simply stays at 0.
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [7:0]      bin;
  logic [11:0]     bcd;
  logic [11:0]     bcd_adj;
  logic [2:0]      cnt;
  logic [3:0]      op_pend;
  logic [3:0]      dig_h, dig_t, dig_o, dig_op;
  logic [PW-1:0]   presc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (load) state_next = SHIFT;
      end
      // cnt==7 marks the 8th shift happening on this edge.
      SHIFT:   if (cnt == 3'd7) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction applied to every BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      op_pend <= '0;
      dig_h   <= '0;
      dig_t   <= '0;
      dig_o   <= '0;
      dig_op  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin     <= value;
            op_pend <= op;
            bcd     <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
          cnt        <= cnt + 3'd1;
        end
        COMMIT: begin
          // All four display registers update together so the scan never
          // shows a half-updated number.
          dig_h  <= bcd[11:8];
          dig_t  <= bcd[7:4];
          dig_o  <= bcd[3:0];
          dig_op <= op_pend;
        end
        default: ;
      endcase
    end
  end

  // Refresh prescaler and digit strobe run independently of conversions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      an    <= 4'b0001;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      an    <= {an[2:0], an[3]};
    end else begin
      presc <= presc + PW'(1);
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  always_comb begin
    seg = 7'h00;
    case (an)
      4'b0001: seg = glyph(dig_o);
      4'b0010: if (!(LZ_BLANK && dig_h == 4'd0 && dig_t == 4'd0)) seg = glyph(dig_t);
      4'b0100: if (!(LZ_BLANK && dig_h == 4'd0)) seg = glyph(dig_h);
      4'b1000: if (dig_op >= 4'hA) seg = glyph(dig_op);
      default: seg = 7'h00;
    endcase
  end

  assign dp = 1'b0;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - testbench for seg7_scan_display
module tb_seg7_scan_display;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = '0;
  logic [3:0] op    = '0;
  logic       load  = 1'b0;

  logic       busy_a, busy_b, dp_a, dp_b;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;

  int vectors = 0;
  int errors  = 0;
  logic [6:0] gly [16];

  always #5 clk = ~clk;

  seg7_scan_display #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .value(value), .op(op), .load(load),
    .busy(busy_a), .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  seg7_scan_display #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .reset(reset), .value(value), .op(op), .load(load),
    .busy(busy_b), .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  // Expected segments for digit d of a displayed value/op, from decimal arithmetic.
  function automatic logic [6:0] model_seg(input int v, input int o, input bit lz, input int d);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    case (d)
      0: return gly[u];
      1: return (lz && h == 0 && t == 0) ? 7'h00 : gly[t];
      2: return (lz && h == 0) ? 7'h00 : gly[h];
      default: return (o >= 10) ? gly[o] : 7'h00;
    endcase
  endfunction

  // Waits (bounded) until the chosen DUT selects digit d, returns its segments or X on timeout.
  task automatic get_digit(input int which, input int d, output logic [6:0] s);
    logic found;
    logic [3:0] want;
    want  = 4'(1 << d);
    found = 1'b0;
    s     = 'x;
    for (int i = 0; i < 32; i++) begin
      if (!found) begin
        if ((which == 0 ? an_a : an_b) == want) begin
          s     = (which == 0) ? seg_a : seg_b;
          found = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic pulse_load(input logic [7:0] v, input logic [3:0] o);
    value = v;
    op    = o;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (busy_a !== 1'b0) @(negedge clk);
    end
    vectors++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after 30 cycles, expected 0", busy_a);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    @(negedge clk);
    @(negedge clk);
    vectors += 4;
    if (an_a !== 4'b0001) begin errors++; $display("FAIL reset_an: got %b expected 0001", an_a); end
    if (seg_a !== 7'h3F)  begin errors++; $display("FAIL reset_seg: got %h expected 3F", seg_a); end
    if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    if (dp_a !== 1'b0)    begin errors++; $display("FAIL reset_dp: got %b expected 0", dp_a); end
    reset = 1'b0;
    for (int cyc = 0; cyc <= 16; cyc++) begin
      exp_an = 4'(1 << ((cyc / 4) % 4));
      vectors += 2;
      if (an_a !== exp_an) begin
        errors++;
        $display("FAIL reset_scan_an cyc %0d: got %b expected %b", cyc, an_a, exp_an);
      end
      if (seg_a !== model_seg(0, 0, 1'b1, (cyc / 4) % 4)) begin
        errors++;
        $display("FAIL reset_scan_seg cyc %0d: got %h expected %h", cyc, seg_a, model_seg(0, 0, 1'b1, (cyc / 4) % 4));
      end
      if (cyc < 16) @(negedge clk);
    end
  endtask

  task automatic test_full_scale();
    logic [6:0] s;
    pulse_load(8'd255, 4'hA);
    for (int j = 0; j <= 8; j++) begin
      vectors++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL full_busy edge k+%0d: got %b expected 1", j, busy_a); end
      @(negedge clk);
    end
    vectors++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL full_busy edge k+9: got %b expected 0", busy_a); end
    for (int d = 0; d < 4; d++) begin
      get_digit(0, d, s);
      vectors++;
      if (s !== model_seg(255, 10, 1'b1, d)) begin
        errors++; $display("FAIL full_digit%0d: got %h expected %h", d, s, model_seg(255, 10, 1'b1, d));
      end
    end
  endtask

  task automatic test_lz_blank();
    int vals [6] = '{7, 100, 0, 10, 99, 105};
    int ops  [6] = '{3, 0, 12, 9, 14, 11};
    logic [6:0] s;
    for (int n = 0; n < 6; n++) begin
      pulse_load(8'(vals[n]), 4'(ops[n]));
      wait_idle();
      for (int d = 0; d < 4; d++) begin
        get_digit(0, d, s);
        vectors++;
        if (s !== model_seg(vals[n], ops[n], 1'b1, d)) begin
          errors++; $display("FAIL lz_on v=%0d digit%0d: got %h expected %h", vals[n], d, s, model_seg(vals[n], ops[n], 1'b1, d));
        end
        get_digit(1, d, s);
        vectors++;
        if (s !== model_seg(vals[n], ops[n], 1'b0, d)) begin
          errors++; $display("FAIL lz_off v=%0d digit%0d: got %h expected %h", vals[n], d, s, model_seg(vals[n], ops[n], 1'b0, d));
        end
      end
    end
  endtask

  task automatic test_load_while_busy();
    logic [6:0] s;
    pulse_load(8'd42, 4'h0);          // edge k
    @(negedge clk);
    @(negedge clk);
    pulse_load(8'd99, 4'hB);          // edge k+3, must be ignored
    repeat (6) @(negedge clk);        // now after edge k+9
    vectors++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL lwb_busy k+9: got %b expected 0", busy_a); end
    @(negedge clk);
    vectors++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL lwb_not_queued: got %b expected 0", busy_a); end
    for (int d = 0; d < 4; d++) begin
      get_digit(0, d, s);
      vectors++;
      if (s !== model_seg(42, 0, 1'b1, d)) begin
        errors++; $display("FAIL lwb_42 digit%0d: got %h expected %h", d, s, model_seg(42, 0, 1'b1, d));
      end
    end
    pulse_load(8'd99, 4'hB);
    wait_idle();
    for (int d = 0; d < 4; d++) begin
      get_digit(0, d, s);
      vectors++;
      if (s !== model_seg(99, 11, 1'b1, d)) begin
        errors++; $display("FAIL lwb_99 digit%0d: got %h expected %h", d, s, model_seg(99, 11, 1'b1, d));
      end
    end
  endtask

  task automatic test_back_to_back();
    int va, vb, vc;
    logic [6:0] s;
    va = $urandom_range(0, 255);
    vb = $urandom_range(0, 255);
    vc = $urandom_range(0, 255);
    pulse_load(8'(va), 4'hC);         // edge k
    repeat (7) @(negedge clk);        // after edge k+7
    pulse_load(8'(vb), 4'hD);         // edge k+8 while COMMIT pending: ignored
    @(negedge clk);                   // after edge k+9
    vectors++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_ignored: got busy %b expected 0", busy_a); end
    pulse_load(8'(vc), 4'hE);         // edge k+10: accepted
    vectors++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept k+10: got busy %b expected 1", busy_a); end
    wait_idle();
    for (int d = 0; d < 4; d++) begin
      get_digit(0, d, s);
      vectors++;
      if (s !== model_seg(vc, 14, 1'b1, d)) begin
        errors++; $display("FAIL b2b v=%0d digit%0d: got %h expected %h", vc, d, s, model_seg(vc, 14, 1'b1, d));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] s;
    pulse_load(8'd200, 4'hF);         // edge k
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors += 3;
    if (busy_a !== 1'b0)  begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy_a); end
    if (an_a !== 4'b0001) begin errors++; $display("FAIL rmid_an: got %b expected 0001", an_a); end
    if (seg_a !== 7'h3F)  begin errors++; $display("FAIL rmid_seg: got %h expected 3F", seg_a); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++;
      if (busy_a !== 1'b0) begin errors++; $display("FAIL rmid_idle cyc %0d: got %b expected 0", i, busy_a); end
    end
    for (int d = 0; d < 4; d++) begin
      get_digit(0, d, s);
      vectors++;
      if (s !== model_seg(0, 0, 1'b1, d)) begin
        errors++; $display("FAIL rmid digit%0d: got %h expected %h", d, s, model_seg(0, 0, 1'b1, d));
      end
    end
  endtask

  task automatic test_operators();
    int ops [8] = '{13, 15, 9, 10, 11, 12, 14, 0};
    int v;
    logic [6:0] s;
    for (int n = 0; n < 8; n++) begin
      v = $urandom_range(0, 255);
      pulse_load(8'(v), 4'(ops[n]));
      wait_idle();
      get_digit(0, 3, s);
      vectors++;
      if (s !== model_seg(v, ops[n], 1'b1, 3)) begin
        errors++; $display("FAIL op 0x%0h: got %h expected %h", ops[n], s, model_seg(v, ops[n], 1'b1, 3));
      end
      get_digit(0, 0, s);
      vectors++;
      if (s !== model_seg(v, ops[n], 1'b1, 0)) begin
        errors++; $display("FAIL op_ones v=%0d: got %h expected %h", v, s, model_seg(v, ops[n], 1'b1, 0));
      end
    end
  endtask

  task automatic test_random();
    int v, o;
    logic [6:0] s;
    for (int n = 0; n < 20; n++) begin
      v = $urandom_range(0, 255);
      o = $urandom_range(0, 15);
      pulse_load(8'(v), 4'(o));
      wait_idle();
      for (int d = 0; d < 4; d++) begin
        get_digit(0, d, s);
        vectors++;
        if (s !== model_seg(v, o, 1'b1, d)) begin
          errors++; $display("FAIL rand_a v=%0d op=%0d digit%0d: got %h expected %h", v, o, d, s, model_seg(v, o, 1'b1, d));
        end
        get_digit(1, d, s);
        vectors++;
        if (s !== model_seg(v, o, 1'b0, d)) begin
          errors++; $display("FAIL rand_b v=%0d op=%0d digit%0d: got %h expected %h", v, o, d, s, model_seg(v, o, 1'b0, d));
        end
      end
      vectors++;
      if (dp_a !== 1'b0 || dp_b !== 1'b0) begin
        errors++; $display("FAIL rand_dp: got %b/%b expected 0/0", dp_a, dp_b);
      end
    end
  endtask

  initial begin
    gly = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    test_reset();
    test_full_scale();
    test_lz_blank();
    test_load_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_operators();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1);
  end

endmodule
